// File: rtl/change_dispenser.sv
// Purpose: pays a change amount as 10/5/1 yuan coins, largest first, and tracks hopper inventory.
// Latency: one coin every 1+PULSE_CYCLES+GAP_CYCLES cycles; done follows the last coin's gap by 2 cycles.
// Backpressure: start is accepted only in IDLE (busy low); an empty hopper set parks the block in FAULT until refill.
module change_dispenser #(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 2,
  parameter int INV_W        = 8,
  parameter int INIT_1       = 20,
  parameter int INIT_5       = 10,
  parameter int INIT_10      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       amount,
  input  logic             refill,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic             eject_1,
  output logic             eject_5,
  output logic             eject_10,
  output logic [7:0]       remaining,
  output logic [INV_W-1:0] cnt_1,
  output logic [INV_W-1:0] cnt_5,
  output logic [INV_W-1:0] cnt_10
);

  // One down-counter times both the pulse and the gap, so size it for the longer one.
  localparam int TMR_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);

  localparam logic [INV_W-1:0] INV_INIT_1  = INV_W'(INIT_1);
  localparam logic [INV_W-1:0] INV_INIT_5  = INV_W'(INIT_5);
  localparam logic [INV_W-1:0] INV_INIT_10 = INV_W'(INIT_10);
  localparam logic [INV_W-1:0] INV_ONE     = INV_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_PULSE,
    S_GAP,
    S_DONE,
    S_FAULT
  } state_t;

  state_t           state, state_n;
  logic [TMR_W-1:0] tmr, tmr_n;
  logic [7:0]       rem_n;
  logic [INV_W-1:0] cnt_1_n, cnt_5_n, cnt_10_n;
  logic             eject_1_n, eject_5_n, eject_10_n;
  logic             busy_n, done_n, fault_n;

  // Greedy coin choice; a hopper is only a candidate while it still holds coins.
  logic pick_10, pick_5, pick_1;
  assign pick_10 = (remaining >= 8'd10) && (cnt_10 != '0);
  assign pick_5  = !pick_10 && (remaining >= 8'd5) && (cnt_5 != '0);
  assign pick_1  = !pick_10 && !pick_5 && (cnt_1 != '0);

  // Next-state, datapath and registered-output values for every state.
  always_comb begin
    state_n    = state;
    tmr_n      = tmr;
    rem_n      = remaining;
    cnt_1_n    = cnt_1;
    cnt_5_n    = cnt_5;
    cnt_10_n   = cnt_10;
    eject_1_n  = 1'b0;
    eject_5_n  = 1'b0;
    eject_10_n = 1'b0;

    case (state)
      S_IDLE: begin
        // Refill and start are independent here: both may act on the same edge.
        if (refill) begin
          cnt_1_n  = INV_INIT_1;
          cnt_5_n  = INV_INIT_5;
          cnt_10_n = INV_INIT_10;
        end
        if (start) begin
          if (amount != 8'd0) begin
            rem_n   = amount;
            state_n = S_SELECT;
          end else begin
            state_n = S_DONE;
          end
        end
      end

      S_SELECT: begin
        // The coin is committed on the edge leaving SELECT: eject rises, balance
        // and inventory drop together, so a later reset never double-counts it.
        if (remaining == 8'd0) begin
          state_n = S_DONE;
        end else if (pick_10) begin
          eject_10_n = 1'b1;
          rem_n      = remaining - 8'd10;
          cnt_10_n   = cnt_10 - INV_ONE;
          tmr_n      = PULSE_LOAD;
          state_n    = S_PULSE;
        end else if (pick_5) begin
          eject_5_n = 1'b1;
          rem_n     = remaining - 8'd5;
          cnt_5_n   = cnt_5 - INV_ONE;
          tmr_n     = PULSE_LOAD;
          state_n   = S_PULSE;
        end else if (pick_1) begin
          eject_1_n = 1'b1;
          rem_n     = remaining - 8'd1;
          cnt_1_n   = cnt_1 - INV_ONE;
          tmr_n     = PULSE_LOAD;
          state_n   = S_PULSE;
        end else begin
          state_n = S_FAULT;
        end
      end

      S_PULSE: begin
        // Hold whichever eject line is active until the pulse timer expires.
        if (tmr == '0) begin
          tmr_n   = GAP_LOAD;
          state_n = S_GAP;
        end else begin
          eject_1_n  = eject_1;
          eject_5_n  = eject_5;
          eject_10_n = eject_10;
          tmr_n      = tmr - TMR_ONE;
        end
      end

      S_GAP: begin
        if (tmr == '0) begin
          state_n = S_SELECT;
        end else begin
          tmr_n = tmr - TMR_ONE;
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
      end

      S_FAULT: begin
        // Only a refill gets out of FAULT; the unpaid balance is kept and resumed.
        if (refill) begin
          cnt_1_n  = INV_INIT_1;
          cnt_5_n  = INV_INIT_5;
          cnt_10_n = INV_INIT_10;
          state_n  = S_SELECT;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Status flags are derived from the state being entered so they register in step with it.
    busy_n  = (state_n != S_IDLE);
    done_n  = (state_n == S_DONE);
    fault_n = (state_n == S_FAULT);
  end

  // State register and all registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tmr       <= '0;
      remaining <= 8'd0;
      cnt_1     <= INV_INIT_1;
      cnt_5     <= INV_INIT_5;
      cnt_10    <= INV_INIT_10;
      eject_1   <= 1'b0;
      eject_5   <= 1'b0;
      eject_10  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_n;
      tmr       <= tmr_n;
      remaining <= rem_n;
      cnt_1     <= cnt_1_n;
      cnt_5     <= cnt_5_n;
      cnt_10    <= cnt_10_n;
      eject_1   <= eject_1_n;
      eject_5   <= eject_5_n;
      eject_10  <= eject_10_n;
      busy      <= busy_n;
      done      <= done_n;
      fault     <= fault_n;
    end
  end

endmodule
